ppdu_builder: RTL and testbench



---
 rtl/comm_pkg.sv | 19 +
 rtl/fcs_crc16.sv | 21 ++
 rtl/ppdu_builder.sv | 152 +++++++++++++++
 tb/tb_ppdu_builder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the PPDU transmit path.
package comm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LOAD        = 3'd1,
      ST_DROP        = 3'd2,
      ST_SEND_PHR    = 3'd3,
      ST_SEND_DATA   = 3'd4,
      ST_SEND_FCS_LO = 3'd5,
      ST_SEND_FCS_HI = 3'd6
   } ppdu_state_t;

   localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
   localparam logic [15:0] CRC16_INIT      = 16'h0000;
   localparam int unsigned MAX_PHY_PACKET  = 127;
   localparam int unsigned FCS_LEN         = 2;

endpackage

// File: rtl/fcs_crc16.sv
// Combinational CRC-16/KERMIT step over one byte, processed LSB first.
module fcs_crc16
   import comm_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] c;

   always_comb begin
      c = crc_in;
      for (int unsigned i = 0; i < 8; i++) begin
         if (c[0] ^ data_in[i]) c = (c >> 1) ^ CRC16_POLY_REFL;
         else                   c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/ppdu_builder.sv
// Buffers one MAC payload, computes its FCS and emits PHR, payload and FCS
// bytes to the framing encoder at one byte per BYTE_PERIOD cycles.
module ppdu_builder
   import comm_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = 125,
   parameter int unsigned BYTE_PERIOD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] mac_data,
   input  logic       mac_valid,
   input  logic       mac_last,
   output logic       mac_ready,
   output logic [7:0] phr_psdu_in,
   output logic       phr_psdu_in_valid,
   output logic       tx_busy,
   output logic       frame_drop
);

   localparam int unsigned    PW          = $clog2(BYTE_PERIOD + 1);
   localparam logic [PW-1:0]  PACE_RELOAD = PW'(BYTE_PERIOD - 1);
   localparam logic [6:0]     MAX_LEN     = 7'(MAX_PAYLOAD);
   localparam logic [6:0]     PHR_ADD     = 7'(FCS_LEN + 1);

   ppdu_state_t   state;
   logic [6:0]    length;
   logic [6:0]    rd_ptr;
   logic [6:0]    rd_nxt;
   logic [15:0]   crc;
   logic [15:0]   crc_next;
   logic [PW-1:0] pace;
   logic [7:0]    pf_data;
   logic [7:0]    buffer [0:MAX_PAYLOAD-1];
   logic          xfer;
   logic          loading;

   fcs_crc16 u_crc (
      .crc_in  (crc),
      .data_in (mac_data),
      .crc_out (crc_next)
   );

   always_comb begin
      mac_ready = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_DROP);
      loading   = (state == ST_IDLE) || (state == ST_LOAD);
      xfer      = mac_valid && mac_ready;
      rd_nxt    = rd_ptr + 7'd1;
   end

   // length doubles as the write pointer
   always_ff @(posedge clk) begin
      if (xfer && loading && (length < MAX_LEN)) buffer[length] <= mac_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         length            <= '0;
         rd_ptr            <= '0;
         crc               <= CRC16_INIT;
         pace              <= '0;
         pf_data           <= '0;
         phr_psdu_in       <= '0;
         phr_psdu_in_valid <= 1'b0;
         tx_busy           <= 1'b0;
         frame_drop        <= 1'b0;
      end else begin
         phr_psdu_in_valid <= 1'b0;
         frame_drop        <= 1'b0;
         case (state)
            ST_IDLE, ST_LOAD: begin
               if (xfer) begin
                  if (length == MAX_LEN) begin
                     if (mac_last) begin
                        frame_drop <= 1'b1;
                        state      <= ST_IDLE;
                        length     <= '0;
                        crc        <= CRC16_INIT;
                     end else begin
                        state <= ST_DROP;
                     end
                  end else begin
                     length <= length + 7'd1;
                     crc    <= crc_next;
                     if (mac_last) begin
                        state             <= ST_SEND_PHR;
                        phr_psdu_in       <= {1'b0, length + PHR_ADD};
                        phr_psdu_in_valid <= 1'b1;
                        tx_busy           <= 1'b1;
                        pace              <= PACE_RELOAD;
                        rd_ptr            <= '0;
                        // a one-byte frame is still being written, so bypass the buffer
                        pf_data           <= (length == '0) ? mac_data : buffer[0];
                     end else begin
                        state <= ST_LOAD;
                     end
                  end
               end
            end
            ST_DROP: begin
               if (xfer && mac_last) begin
                  frame_drop <= 1'b1;
                  state      <= ST_IDLE;
                  length     <= '0;
                  crc        <= CRC16_INIT;
               end
            end
            ST_SEND_PHR, ST_SEND_DATA: begin
               if (pace != '0) begin
                  pace <= pace - 1'b1;
               end else begin
                  pace              <= PACE_RELOAD;
                  phr_psdu_in_valid <= 1'b1;
                  if (rd_ptr == length) begin
                     phr_psdu_in <= crc[7:0];
                     state       <= ST_SEND_FCS_LO;
                  end else begin
                     phr_psdu_in <= pf_data;
                     rd_ptr      <= rd_nxt;
                     if (rd_nxt < MAX_LEN) pf_data <= buffer[rd_nxt];
                     state       <= ST_SEND_DATA;
                  end
               end
            end
            ST_SEND_FCS_LO: begin
               if (pace != '0) begin
                  pace <= pace - 1'b1;
               end else begin
                  pace              <= PACE_RELOAD;
                  phr_psdu_in_valid <= 1'b1;
                  phr_psdu_in       <= crc[15:8];
                  state             <= ST_SEND_FCS_HI;
               end
            end
            ST_SEND_FCS_HI: begin
               if (pace != '0) begin
                  pace <= pace - 1'b1;
               end else begin
                  state   <= ST_IDLE;
                  tx_busy <= 1'b0;
                  length  <= '0;
                  rd_ptr  <= '0;
                  crc     <= CRC16_INIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ppdu_builder.sv
// Bench for ppdu_builder: two instances (BYTE_PERIOD 8 and 1) checked
// against a table-driven CRC-16/KERMIT model and expected pulse timing.
module tb_ppdu_builder;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      int          cyc;
      logic [7:0]  data;
   } pulse_t;
   typedef struct {
      int          sel;
      int          n;
      logic [7:0]  first;
      logic [7:0]  step;
      bit          gap;
      bit          fixed;
      logic [15:0] fcs;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] mac_data;
   logic       mac_last;
   logic       valid0, valid1;
   logic       ready0, ready1;
   logic [7:0] out0, out1;
   logic       pv0, pv1, busy0, busy1, drop0, drop1;

   ppdu_builder #(.MAX_PAYLOAD(125), .BYTE_PERIOD(8)) dut8 (
      .clk(clk), .reset(reset), .mac_data(mac_data), .mac_valid(valid0),
      .mac_last(mac_last), .mac_ready(ready0), .phr_psdu_in(out0),
      .phr_psdu_in_valid(pv0), .tx_busy(busy0), .frame_drop(drop0)
   );

   ppdu_builder #(.MAX_PAYLOAD(125), .BYTE_PERIOD(1)) dut1 (
      .clk(clk), .reset(reset), .mac_data(mac_data), .mac_valid(valid1),
      .mac_last(mac_last), .mac_ready(ready1), .phr_psdu_in(out1),
      .phr_psdu_in_valid(pv1), .tx_busy(busy1), .frame_drop(drop1)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   pulse_t cap0[$];
   pulse_t cap1[$];
   int ready_lo[2];
   int busy_hi[2];
   int drops[2];
   int drop_cyc[2];

   always @(negedge clk) begin
      if (pv0) cap0.push_back('{cyc, out0});
      if (pv1) cap1.push_back('{cyc, out1});
      if (!ready0) ready_lo[0]++;
      if (!ready1) ready_lo[1]++;
      if (busy0) busy_hi[0]++;
      if (busy1) busy_hi[1]++;
      if (drop0) begin drops[0]++; drop_cyc[0] = cyc; end
      if (drop1) begin drops[1]++; drop_cyc[1] = cyc; end
   end

   int passes = 0;
   int total  = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   function automatic logic [15:0] kermit_ref(input byte_q_t msg);
      logic [15:0] tbl [256];
      logic [15:0] r;
      for (int i = 0; i < 256; i++) begin
         r = 16'(i);
         for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
         tbl[i] = r;
      end
      r = 16'h0000;
      foreach (msg[k]) r = (r >> 8) ^ tbl[r[7:0] ^ msg[k]];
      return r;
   endfunction

   function automatic bit rdy(input int sel);
      return (sel == 0) ? ready0 : ready1;
   endfunction

   function automatic int capsize(input int sel);
      return (sel == 0) ? cap0.size() : cap1.size();
   endfunction

   task automatic set_valid(input int sel, input logic v);
      if (sel == 0) valid0 = v;
      else          valid1 = v;
   endtask

   task automatic clear_mon(input int sel);
      if (sel == 0) cap0.delete();
      else          cap1.delete();
      ready_lo[sel] = 0;
      busy_hi[sel]  = 0;
      drops[sel]    = 0;
      drop_cyc[sel] = -1;
   endtask

   task automatic send_frame(input int sel, input byte_q_t msg, input bit gap, output int hs_cyc);
      int w;
      hs_cyc = -1;
      @(negedge clk);
      for (int i = 0; i < msg.size(); i++) begin
         mac_data = msg[i];
         mac_last = (i == msg.size() - 1);
         set_valid(sel, 1'b1);
         w = 0;
         while (!rdy(sel) && w < 2000) begin @(negedge clk); w++; end
         if (!rdy(sel)) begin
            check("handshake_timeout", 0, 1);
            set_valid(sel, 1'b0);
            break;
         end
         hs_cyc = cyc;
         @(negedge clk);
         set_valid(sel, 1'b0);
         mac_last = 1'b0;
         if (gap) @(negedge clk);
      end
   endtask

   task automatic expect_frame(input int sel, input string tag, input byte_q_t msg,
                               input int hs, input logic [15:0] fcs_exp);
      int bp, npl, w, got;
      byte_q_t exp;
      pulse_t p;
      bp  = (sel == 0) ? 8 : 1;
      npl = msg.size() + 3;
      exp.push_back(8'(msg.size() + 2));
      foreach (msg[i]) exp.push_back(msg[i]);
      exp.push_back(fcs_exp[7:0]);
      exp.push_back(fcs_exp[15:8]);
      w = 0;
      while ((capsize(sel) < npl || !rdy(sel)) && w < npl * bp + 50) begin
         @(negedge clk); w++;
      end
      repeat (3) @(negedge clk);
      got = capsize(sel);
      check({tag, " pulse_count"}, got, npl);
      for (int k = 0; k < npl && k < got; k++) begin
         p = (sel == 0) ? cap0[k] : cap1[k];
         check($sformatf("%s byte%0d", tag, k), int'(p.data), int'(exp[k]));
         check($sformatf("%s time%0d", tag, k), p.cyc - hs, 1 + k * bp);
      end
      check({tag, " ready_low_cycles"}, ready_lo[sel], npl * bp);
      check({tag, " busy_cycles"}, busy_hi[sel], npl * bp);
      check({tag, " no_drop"}, drops[sel], 0);
   endtask

   vec_t vecs[4];

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      byte_q_t msg;
      int hs, cnt, w, sel, n;
      logic [7:0] b;
      logic [15:0] fcs;

      vecs[0] = '{0,   9, 8'h31, 8'h01, 1'b0, 1'b1, 16'h2189};
      vecs[1] = '{0,   1, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000};
      vecs[2] = '{0, 125, 8'h00, 8'h01, 1'b0, 1'b0, 16'h0000};
      vecs[3] = '{1,   2, 8'hA5, 8'hB5, 1'b1, 1'b0, 16'h0000};

      reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; mac_data = '0; mac_last = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset ready8", int'(ready0), 1);
      check("reset ready1", int'(ready1), 1);
      check("reset valid8", int'(pv0), 0);
      check("reset data8", int'(out0), 0);
      check("reset busy8", int'(busy0), 0);
      check("reset drop8", int'(drop0), 0);
      check("reset valid1", int'(pv1), 0);
      check("reset busy1", int'(busy1), 0);

      foreach (vecs[v]) begin
         msg.delete();
         b = vecs[v].first;
         for (int i = 0; i < vecs[v].n; i++) begin msg.push_back(b); b = b + vecs[v].step; end
         fcs = vecs[v].fixed ? vecs[v].fcs : kermit_ref(msg);
         clear_mon(vecs[v].sel);
         send_frame(vecs[v].sel, msg, vecs[v].gap, hs);
         expect_frame(vecs[v].sel, $sformatf("vec%0d", v), msg, hs, fcs);
      end

      // oversize frame is discarded, then a short frame goes through
      msg.delete();
      for (int i = 0; i < 126; i++) msg.push_back(8'(i));
      clear_mon(0);
      send_frame(0, msg, 1'b0, hs);
      repeat (20) @(negedge clk);
      check("drop pulses", drops[0], 1);
      check("drop timing", drop_cyc[0] - hs, 1);
      check("drop no_output", cap0.size(), 0);
      check("drop ready_held", ready_lo[0], 0);
      msg.delete();
      for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
      clear_mon(0);
      send_frame(0, msg, 1'b0, hs);
      expect_frame(0, "after_drop", msg, hs, kermit_ref(msg));

      // reset on the 4th pulse of a 9-byte frame
      msg.delete();
      for (int i = 0; i < 9; i++) msg.push_back(8'($urandom));
      clear_mon(0);
      send_frame(0, msg, 1'b0, hs);
      cnt = 0; w = 0;
      while (w < 200) begin
         if (pv0) begin cnt++; if (cnt == 4) break; end
         @(negedge clk); w++;
      end
      check("midreset reached_pulse4", cnt, 4);
      reset = 1'b1;
      @(negedge clk);
      check("midreset valid", int'(pv0), 0);
      check("midreset busy", int'(busy0), 0);
      check("midreset ready", int'(ready0), 1);
      check("midreset data", int'(out0), 0);
      reset = 1'b0;
      clear_mon(0);
      repeat (100) @(negedge clk);
      check("midreset no_more_pulses", cap0.size(), 0);
      msg.delete();
      msg.push_back(8'h00);
      clear_mon(0);
      send_frame(0, msg, 1'b0, hs);
      expect_frame(0, "post_reset", msg, hs, 16'h0000);

      // randomized frames on both instances
      for (int r = 0; r < 8; r++) begin
         sel = r % 2;
         n = $urandom_range(1, 24);
         msg.delete();
         for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
         clear_mon(sel);
         send_frame(sel, msg, 1'($urandom), hs);
         expect_frame(sel, $sformatf("rand%0d", r), msg, hs, kermit_ref(msg));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
